// File: rtl/led_blink_decoder.sv
// Recovers blink period / high time from an async LED line and flags a stuck line.
// Optional input glitch filter enabled by LED_DEBOUNCE_EN.
module led_blink_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int DEB_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level,
    output logic [7:0]       edge_cnt
);

    typedef enum logic [1:0] {IDLE, FIRST, RUN, STUCK} state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);

    state_t           state;
    logic             sync1;
    logic             led_s;
    logic             led_f;
    logic             led_q;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cap;
    logic             rise;
    logic             fall;
    logic             tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            led_s <= 1'b0;
        end else begin
            sync1 <= led_in;
            led_s <= sync1;
        end
    end

`ifdef LED_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_LEN + 1);

    logic [DW-1:0] deb_cnt;

    // led_f flips only after led_s disagrees for DEB_LEN straight cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            led_f   <= 1'b0;
        end else if (led_s == led_f) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_LEN - 1)) begin
            deb_cnt <= '0;
            led_f   <= led_s;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end
`else
    assign led_f = led_s;
`endif

    assign rise = led_f & ~led_q;
    assign fall = ~led_f & led_q;
    assign tmo  = (per_cnt == TO) && !rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            led_q       <= 1'b0;
            per_cnt     <= '0;
            hi_cap      <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
            edge_cnt    <= '0;
        end else begin
            led_q      <= led_f;
            meas_valid <= 1'b0;

            if (rise)
                per_cnt <= CNT_W'(1);
            else if (per_cnt != CMAX)
                per_cnt <= per_cnt + 1'b1;

            if (fall)
                hi_cap <= per_cnt;

            if (rise)
                edge_cnt <= edge_cnt + 8'd1;

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state <= FIRST;
                    end else if (tmo) begin
                        state       <= STUCK;
                        stuck       <= 1'b1;
                        stuck_level <= led_f;
                    end
                end
                FIRST, RUN: begin
                    if (rise) begin
                        period     <= per_cnt;
                        high_time  <= hi_cap;
                        meas_valid <= 1'b1;
                        state      <= RUN;
                    end else if (tmo) begin
                        state       <= STUCK;
                        stuck       <= 1'b1;
                        stuck_level <= led_f;
                    end
                end
                STUCK: begin
                    // recovery rise only re-arms; it has no valid previous period
                    if (rise) begin
                        stuck <= 1'b0;
                        state <= FIRST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_decoder.sv
// Scoreboard bench for led_blink_decoder: a waveform driver predicts each
// measurement; a negedge monitor pops and compares on every meas_valid.
module tb_led_blink_decoder;

    localparam int CW = 16;
    localparam int TO = 50;
    localparam int DL = 3;
`ifdef LED_DEBOUNCE_EN
    localparam int LX   = DL;
    localparam int DEBL = DL;
`else
    localparam int LX   = 0;
    localparam int DEBL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          led_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          stuck;
    logic          stuck_level;
    logic [7:0]    edge_cnt;

    always #2 clk = ~clk;

    led_blink_decoder #(
        .CNT_W(CW),
        .TIMEOUT(TO),
        .DEB_LEN(DL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .led_in(led_in),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .stuck(stuck),
        .stuck_level(stuck_level),
        .edge_cnt(edge_cnt)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    logic [31:0] e;
    int          since_rise = 0;
    int          last_hi = 0;
    int          edges = 0;
    bit          have_prev = 0;
    bit          cur = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive a level for n cycles and predict what the decoder will see
    task automatic drv(bit lvl, int n);
        led_in = lvl;
        if (lvl && !cur && n >= DEBL) begin
            if (have_prev)
                sb.push_back({16'(since_rise), 16'(last_hi)});
            have_prev  = 1;
            since_rise = 0;
            edges      = (edges + 1) % 256;
            cur        = 1;
            last_hi    = n;
        end else if (lvl && cur) begin
            last_hi += n;
        end else if (!lvl) begin
            cur = 0;
        end
        since_rise += n;
        repeat (n) step();
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        repeat (2) step();
        rst        = 1'b0;
        have_prev  = 0;
        cur        = 0;
        since_rise = 0;
        last_hi    = 0;
        edges      = 0;
    endtask

    task automatic chk_zero(string t);
        @(negedge clk);
        chk({t, "_period"}, period, 0);
        chk({t, "_high"}, high_time, 0);
        chk({t, "_mv"}, meas_valid, 0);
        chk({t, "_stuck"}, stuck, 0);
        chk({t, "_level"}, stuck_level, 0);
        chk({t, "_edges"}, edge_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (meas_valid) begin
            if (sb.size() == 0) begin
                chk("mv_unexpected", meas_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("period", period, e[31:16]);
                chk("high", high_time, e[15:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        led_in = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk_zero("reset");

        // clean 10/4 blinking
        repeat (5) begin
            drv(1, 4);
            drv(0, 6);
        end
        @(negedge clk);
        chk("a_edges", edge_cnt, edges);
        chk("a_stuck", stuck, 0);

        // stuck low after the last rise, exact cycle
        repeat (2) begin
            drv(1, 4);
            drv(0, 6);
        end
        drv(1, 4);
        drv(0, 48 + LX);
        @(negedge clk);
        chk("b_pre_stuck", stuck, 0);
        drv(0, 1);
        @(negedge clk);
        chk("b_stuck", stuck, 1);
        chk("b_level", stuck_level, 0);
        chk("b_period", period, 10);
        chk("b_high", high_time, 4);
        chk("b_edges", edge_cnt, edges);
        have_prev = 0;
        drv(0, 5);
        drv(1, 4);
        drv(0, 6);
        chk("b_unstuck", stuck, 0);
        repeat (2) begin
            drv(1, 4);
            drv(0, 6);
        end
        @(negedge clk);
        chk("b_edges2", edge_cnt, edges);

        // mid-stream reset
        drv(0, 4);
        rst_pulse();
        chk_zero("c_reset");
        repeat (3) begin
            drv(1, 4);
            drv(0, 6);
        end
        @(negedge clk);
        chk("c_edges", edge_cnt, edges);

        // line high from reset
        rst_pulse();
        drv(1, 60);
        @(negedge clk);
        chk("d_stuck", stuck, 1);
        chk("d_level", stuck_level, 1);
        chk("d_edges", edge_cnt, edges);
        have_prev = 0;
        drv(0, 6);
        drv(1, 4);
        drv(0, 6);
        chk("d_unstuck", stuck, 0);
        drv(1, 4);
        drv(0, 6);

        // edge counter wrap
        drv(0, 4);
        rst_pulse();
        repeat (300) begin
            drv(1, 3);
            drv(0, 3);
        end
        drv(0, 6);
        @(negedge clk);
        chk("e_edges", edge_cnt, 44);
        chk("e_model_edges", edge_cnt, edges);
        chk("e_stuck", stuck, 0);

`ifdef LED_DEBOUNCE_EN
        drv(0, 10);
        drv(1, 1);
        drv(0, 5);
        drv(1, 2);
        drv(0, 5);
        @(negedge clk);
        chk("f_glitch_edges", edge_cnt, 44);
        drv(1, 3);
        drv(0, 8);
        @(negedge clk);
        chk("f_pulse_edges", edge_cnt, 45);
`endif

        drv(0, 5);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_blink_decoder.md
Name: led_blink_decoder

Overview:
Receive-side counterpart of the LED flasher. It samples an asynchronous blinking LED line and recovers the blink timing: period and high time, both in clk cycles. It also flags a line that has stopped toggling, as stuck high or stuck low. It sits on a board-input or loopback path so that flasher output can be checked in hardware and in simulation benches.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 1000, cycles without a rising edge before stuck is declared. Constraint: 2 <= TIMEOUT <= 2^CNT_W-1.
- DEB_LEN, 3, debounce hold length in cycles. Used only with LED_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- led_in  in  1  asynchronous LED line under observation.
- period  out  CNT_W  cycles between the last two rising edges.
- high_time  out  CNT_W  cycles from a rise to the following fall, for the last complete period.
- meas_valid  out  1  one-cycle pulse when period and high_time update.
- stuck  out  1  high while the line is declared stuck.
- stuck_level  out  1  level of the line at the moment stuck was declared.
- edge_cnt  out  8  count of filtered rising edges; wraps 255 to 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All flops reset only on a clk edge with rst=1.
- Reset values: period=0, high_time=0, meas_valid=0, stuck=0, stuck_level=0, edge_cnt=0. Internal: state=IDLE, per_cnt=0, hi_cap=0, both synchroniser flops=0, led_q=0.
- Input path: 2-flop synchroniser produces led_s. Filtered signal led_f = led_s when the debounce feature is off. led_q is led_f delayed one cycle.
- Edge detection: rise = led_f & ~led_q; fall = ~led_f & led_q.
- per_cnt:
  - loads 1 on rise;
  - otherwise increments by 1 each cycle;
  - saturates at 2^CNT_W-1.
  - Consequence: at a rise, per_cnt equals the cycles since the previous rise.
- hi_cap: loads per_cnt on fall.
- FSM states: IDLE, FIRST, RUN, STUCK.
  - IDLE: on rise, go to FIRST. If per_cnt reaches TIMEOUT, go to STUCK.
  - FIRST: on rise, update period and high_time, pulse meas_valid, go to RUN. On timeout, go to STUCK.
  - RUN: on rise, update and pulse as in FIRST; stay in RUN. On timeout, go to STUCK.
  - STUCK: stuck=1. On rise, clear stuck and go to FIRST. No meas_valid for that rise; period and high_time hold their old values.
- Timeout condition: per_cnt==TIMEOUT with no rise in the same cycle. On entry to STUCK, stuck_level <= led_f.
- Measurement update on a qualifying rise: period <= per_cnt, high_time <= hi_cap.
- Simultaneous events: a rise in the same cycle per_cnt hits TIMEOUT counts as a rise, not a timeout.
- A fall in the same cycle as a rise cannot occur (led_f has one value per cycle).
- edge_cnt increments on every rise in every state.
- Latency: led_in rising, first sampled at edge k, gives meas_valid high in cycle k+3 (no debounce).
- Outputs are registered. period and high_time hold between updates.
- Reset mid-operation: returns to IDLE. The first rise after reset never produces meas_valid.

Optional Feature:
- Macro: LED_DEBOUNCE_EN.
- Defined: led_f changes only after led_s holds the opposite value for DEB_LEN consecutive cycles. Filter counter resets to 0 on rst. Latency grows by DEB_LEN cycles. Pulses or glitches shorter than DEB_LEN cycles are ignored.
- Undefined: led_f = led_s; no filter logic is instantiated. DEB_LEN is unused.

Test Plan:
- Defaults, 4 ns clock. Drive led_in with period 10 cycles, high 4 cycles, for 5 periods → no meas_valid on the first rise; then meas_valid pulses once per period with period=10, high_time=4; edge_cnt=5.
- TIMEOUT=50. After 3 clean periods, hold led_in low → stuck=1 and stuck_level=0 exactly 50 cycles after the last rise; period and high_time unchanged. Resume toggling → stuck clears on the first rise, and meas_valid returns on the second rise.
- TIMEOUT=50. Hold led_in high from reset → stuck=1, stuck_level=1. Next rise → stuck=0, state FIRST.
- Assert rst for 2 cycles mid-stream (rst=1, then 0) → all outputs 0. The first rise after reset gives no meas_valid; the second gives a correct period.
- Drive 300 periods of 6 cycles (high 3) → edge_cnt=44 (300 mod 256); period=6, high_time=3 on every pulse.
- With LED_DEBOUNCE_EN and DEB_LEN=3: inject 1-cycle and 2-cycle high glitches into a low phase → edge_cnt unchanged, no meas_valid. A 3-cycle pulse is counted.
